// File: rtl/address_decoder_ws_pkg.sv
// rtl/address_decoder_ws_pkg.sv - FSM states and default region map for the wait-state decoder
package address_decoder_ws_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  localparam int DEF_NUM_REGIONS = 5;
  localparam int DEF_ADDR_W      = 16;
  localparam int DEF_WS_W        = 3;

  // Region i lives in slice i, so region 0 is the rightmost field.
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_BASE =
    {16'h8000, 16'h7000, 16'h5000, 16'h4000, 16'h0000};
  localparam logic [DEF_NUM_REGIONS*DEF_ADDR_W-1:0] DEF_REGION_LIMIT =
    {16'hFFFF, 16'h7003, 16'h6FFF, 16'h4FFF, 16'h3FFF};
  localparam logic [DEF_NUM_REGIONS*DEF_WS_W-1:0] DEF_REGION_WS =
    {3'd3, 3'd0, 3'd2, 3'd1, 3'd0};

endpackage

// File: rtl/address_decoder_ws_if.sv
// rtl/address_decoder_ws_if.sv - CPU-side access bus of the decoder with cpu (master) and decoder (slave) views
interface address_decoder_ws_if #(
  parameter int NUM_REGIONS = 5,
  parameter int ADDR_W      = 16
);
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [ADDR_W-1:0]      cpu_address;
  logic                   cpu_valid;
  logic                   cpu_rdy;
  logic [NUM_REGIONS-1:0] select;
  logic [IDX_W-1:0]       region_idx;
  logic                   ack;
  logic                   decode_err;
  logic [ADDR_W-1:0]      err_addr;
  logic                   err_clr;

  modport master (
    output cpu_address, cpu_valid, err_clr,
    input  cpu_rdy, select, region_idx, ack, decode_err, err_addr
  );

  modport slave (
    input  cpu_address, cpu_valid, err_clr,
    output cpu_rdy, select, region_idx, ack, decode_err, err_addr
  );
endinterface

// File: rtl/address_decoder_ws_region_match.sv
// rtl/address_decoder_ws_region_match.sv - inclusive base/limit comparator for one region
module region_match_m #(
  parameter int ADDR_W = 16
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W-1:0] limit,
  output logic              hit
);
  // A limit below the base yields an empty range without any special case.
  assign hit = (addr >= base) && (addr <= limit);
endmodule

// File: rtl/address_decoder_ws.sv
// rtl/address_decoder_ws.sv - registered priority region decoder with per-region wait states
// Optional sticky unmapped-address capture: ADDRESS_DECODER_WS_ERR_CAPTURE_EN
module address_decoder_ws
  import address_decoder_ws_pkg::*;
#(
  parameter int NUM_REGIONS = DEF_NUM_REGIONS,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WS_W        = DEF_WS_W,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE  = DEF_REGION_BASE,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_LIMIT = DEF_REGION_LIMIT,
  parameter logic [NUM_REGIONS*WS_W-1:0]   REGION_WS    = DEF_REGION_WS
) (
  input logic clk,
  input logic rst,
  address_decoder_ws_if.slave bus
);
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

  logic [NUM_REGIONS-1:0] match;
  logic [NUM_REGIONS-1:0] dec_onehot;
  logic [IDX_W-1:0]       dec_idx;
  logic [WS_W-1:0]        dec_ws;
  logic                   dec_hit;

  state_t                 state;
  logic [WS_W-1:0]        cnt;
  logic [NUM_REGIONS-1:0] select_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   ack_q;
  logic                   err_q;
  logic                   accept;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_match
    region_match_m #(.ADDR_W(ADDR_W)) u_match (
      .addr  (bus.cpu_address),
      .base  (REGION_BASE[g*ADDR_W +: ADDR_W]),
      .limit (REGION_LIMIT[g*ADDR_W +: ADDR_W]),
      .hit   (match[g])
    );
  end

  // Scanning downward lets the lowest matching index overwrite the others.
  always_comb begin
    dec_onehot = '0;
    dec_idx    = '0;
    dec_ws     = '0;
    dec_hit    = 1'b0;
    for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
      if (match[i]) begin
        dec_onehot    = '0;
        dec_onehot[i] = 1'b1;
        dec_idx       = IDX_W'(i);
        dec_ws        = REGION_WS[i*WS_W +: WS_W];
        dec_hit       = 1'b1;
      end
    end
  end

  assign accept = bus.cpu_valid && (state != ST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      select_q <= '0;
      idx_q    <= '0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE, ST_ACK: begin
          if (bus.cpu_valid) begin
            select_q <= dec_onehot;
            idx_q    <= dec_idx;
            cnt      <= dec_ws;
            if (dec_ws != '0) begin
              state <= ST_WAIT;
            end else begin
              state <= ST_ACK;
              ack_q <= 1'b1;
              err_q <= ~dec_hit;
            end
          end else begin
            state    <= ST_IDLE;
            select_q <= '0;
            idx_q    <= '0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt - WS_W'(1);
          if (cnt == WS_W'(1)) begin
            state <= ST_ACK;
            ack_q <= 1'b1;
          end
        end
        default: begin
          state    <= ST_IDLE;
          select_q <= '0;
          idx_q    <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_rdy    = (state != ST_WAIT);
  assign bus.select     = select_q;
  assign bus.region_idx = idx_q;
  assign bus.ack        = ack_q;
  assign bus.decode_err = err_q;

`ifdef ADDRESS_DECODER_WS_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] err_addr_q;
  logic              err_held;

  // A clear in the same cycle as a new error re-arms and takes the new address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_addr_q <= '0;
      err_held   <= 1'b0;
    end else if (accept && !dec_hit && (!err_held || bus.err_clr)) begin
      err_addr_q <= bus.cpu_address;
      err_held   <= 1'b1;
    end else if (bus.err_clr) begin
      err_addr_q <= '0;
      err_held   <= 1'b0;
    end
  end

  assign bus.err_addr = err_addr_q;
`else
  logic unused_err_inputs;
  assign unused_err_inputs = bus.err_clr ^ accept;
  assign bus.err_addr      = '0;
`endif

endmodule

// File: tb/tb_address_decoder_ws.sv
// tb/tb_address_decoder_ws.sv - directed bench for address_decoder_ws (default map and overlapping-region map)
module tb_address_decoder_ws;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int passes = 0;

  localparam logic [79:0] OVR_BASE  = {16'h8000, 16'h0000, 16'h5000, 16'h4000, 16'h0000};
  localparam logic [79:0] OVR_LIMIT = {16'hFFFF, 16'hFFFF, 16'h6FFF, 16'h4FFF, 16'h3FFF};

  always #5 clk = ~clk;

  address_decoder_ws_if #(.NUM_REGIONS(5), .ADDR_W(16)) bus0 ();
  address_decoder_ws_if #(.NUM_REGIONS(5), .ADDR_W(16)) bus1 ();

  address_decoder_ws dut0 (.clk(clk), .rst(rst), .bus(bus0));

  address_decoder_ws #(.REGION_BASE(OVR_BASE), .REGION_LIMIT(OVR_LIMIT)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] exp_err;
    bus0.cpu_valid = 1'b0; bus0.cpu_address = '0; bus0.err_clr = 1'b0;
    bus1.cpu_valid = 1'b0; bus1.cpu_address = '0; bus1.err_clr = 1'b0;

    #1;
    check("rst_rdy", bus0.cpu_rdy, 1);
    check("rst_sel", bus0.select, 0);
    check("rst_idx", bus0.region_idx, 0);
    check("rst_ack", bus0.ack, 0);
    check("rst_err", bus0.decode_err, 0);
    check("rst_erraddr", bus0.err_addr, 0);
    tick();
    rst = 1'b0;
    tick();

    // zero-wait RAM access
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h1234;
    tick();
    bus0.cpu_valid = 1'b0;
    check("ram_sel", bus0.select, 5'b00001);
    check("ram_ack", bus0.ack, 1);
    check("ram_rdy", bus0.cpu_rdy, 1);
    check("ram_derr", bus0.decode_err, 0);
    tick();
    check("ram_ack_done", bus0.ack, 0);
    check("ram_sel_idle", bus0.select, 0);

    // three wait states
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h8000;
    tick();
    bus0.cpu_valid = 1'b0;
    check("ws3_c1_rdy", bus0.cpu_rdy, 0);
    check("ws3_c1_sel", bus0.select, 5'b10000);
    check("ws3_c1_idx", bus0.region_idx, 4);
    check("ws3_c1_ack", bus0.ack, 0);
    tick();
    check("ws3_c2_rdy", bus0.cpu_rdy, 0);
    check("ws3_c2_ack", bus0.ack, 0);
    tick();
    check("ws3_c3_rdy", bus0.cpu_rdy, 0);
    check("ws3_c3_sel", bus0.select, 5'b10000);
    tick();
    check("ws3_c4_rdy", bus0.cpu_rdy, 1);
    check("ws3_c4_ack", bus0.ack, 1);
    check("ws3_c4_sel", bus0.select, 5'b10000);
    tick();
    check("ws3_c5_ack", bus0.ack, 0);

    // back-to-back 0x4000 (WS1) then 0x7002 (WS0)
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h4000;
    tick();
    check("b2b_c1_rdy", bus0.cpu_rdy, 0);
    check("b2b_c1_sel", bus0.select, 5'b00010);
    tick();
    check("b2b_c2_ack", bus0.ack, 1);
    check("b2b_c2_sel", bus0.select, 5'b00010);
    bus0.cpu_address = 16'h7002;
    tick();
    bus0.cpu_valid = 1'b0;
    check("b2b_c3_ack", bus0.ack, 1);
    check("b2b_c3_sel", bus0.select, 5'b01000);
    check("b2b_c3_idx", bus0.region_idx, 3);
    tick();
    check("b2b_c4_ack", bus0.ack, 0);

    // unmapped accesses and error capture
`ifdef ADDRESS_DECODER_WS_ERR_CAPTURE_EN
    exp_err = 16'h7004;
`else
    exp_err = 16'h0000;
`endif
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h7004;
    tick();
    bus0.cpu_valid = 1'b0;
    check("unm_sel", bus0.select, 0);
    check("unm_idx", bus0.region_idx, 0);
    check("unm_ack", bus0.ack, 1);
    check("unm_derr", bus0.decode_err, 1);
    check("unm_erraddr", bus0.err_addr, exp_err);
    tick();
    check("unm_derr_done", bus0.decode_err, 0);
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h7FFF;
    tick();
    bus0.cpu_valid = 1'b0;
    check("unm2_derr", bus0.decode_err, 1);
    check("unm2_sticky", bus0.err_addr, exp_err);
    tick();
    bus0.err_clr = 1'b1;
    tick();
    bus0.err_clr = 1'b0;
    check("errclr", bus0.err_addr, 0);
`ifdef ADDRESS_DECODER_WS_ERR_CAPTURE_EN
    exp_err = 16'h7FFF;
`endif
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h7FFF; bus0.err_clr = 1'b1;
    tick();
    bus0.cpu_valid = 1'b0; bus0.err_clr = 1'b0;
    check("clr_and_new", bus0.err_addr, exp_err);
    tick();

    // overlapping map: region 0 beats full-range region 3
    bus1.cpu_valid = 1'b1; bus1.cpu_address = 16'h2000;
    tick();
    bus1.cpu_valid = 1'b0;
    check("ovl_sel", bus1.select, 5'b00001);
    check("ovl_idx", bus1.region_idx, 0);
    check("ovl_ack", bus1.ack, 1);
    tick();
    bus1.cpu_valid = 1'b1; bus1.cpu_address = 16'h7004;
    tick();
    bus1.cpu_valid = 1'b0;
    check("ovl_r3_sel", bus1.select, 5'b01000);
    check("ovl_r3_derr", bus1.decode_err, 0);
    tick();

    // reset in the middle of a wait
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h9000;
    tick();
    bus0.cpu_valid = 1'b0;
    check("rstw_rdy", bus0.cpu_rdy, 0);
    check("rstw_sel", bus0.select, 5'b10000);
    tick();
    rst = 1'b1;
    #1;
    check("rstw_async_rdy", bus0.cpu_rdy, 1);
    check("rstw_async_sel", bus0.select, 0);
    check("rstw_async_ack", bus0.ack, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rstw_no_ack", bus0.ack, 0);
    end
    bus0.cpu_valid = 1'b1; bus0.cpu_address = 16'h5000;
    tick();
    bus0.cpu_valid = 1'b0;
    check("post_c1_rdy", bus0.cpu_rdy, 0);
    check("post_c1_sel", bus0.select, 5'b00100);
    check("post_c1_idx", bus0.region_idx, 2);
    tick();
    check("post_c2_rdy", bus0.cpu_rdy, 0);
    tick();
    check("post_c3_ack", bus0.ack, 1);
    check("post_c3_rdy", bus0.cpu_rdy, 1);
    tick();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/address_decoder_ws.md
# address_decoder_ws

Parametrised, registered memory-map decoder with per-region wait-state generation for the CPU bus. Accepts a CPU access, resolves it against a configurable region table (priority first-match), drives a one-hot region select for the duration of the access, and stalls the CPU through `cpu_rdy` for the region's programmed number of wait states. It replaces the fixed combinational decode for systems mixing fast RAM with slow firmware, ROM and VRAM.

## Interface
- `NUM_REGIONS`, 5: number of decoded regions. Range is 1..16.
- `ADDR_W`, 16: CPU address width.
- `WS_W`, 3: wait-state count width. A region may have 0..2^WS_W−1 wait states.
- `REGION_BASE`, default map: packed `NUM_REGIONS*ADDR_W`. Region i occupies slice i.
- `REGION_LIMIT`, default map: packed `NUM_REGIONS*ADDR_W`. The limit is inclusive.
- `REGION_WS`, default map: packed `NUM_REGIONS*WS_W`. Wait states per region.

Ports:
- `clk` in 1: bus clock.
- `rst` in 1: reset. Asynchronous, active-high.
- `cpu_address` in ADDR_W: access address. Sampled only when the access is accepted.
- `cpu_valid` in 1: access request.
- `cpu_rdy` out 1: 0 stalls the CPU.
- `select` out NUM_REGIONS: one-hot region select, registered.
- `region_idx` out $clog2(NUM_REGIONS): index of the matched region.
- `ack` out 1: single-cycle pulse marking access completion.
- `decode_err` out 1: asserted with `ack` when the address is unmapped.
- `err_addr` out ADDR_W: first unmapped address. Present only under the configuration macro.
- `err_clr` in 1: clears the error capture.

## Operation
- **Match rule.** Region i matches when `REGION_BASE[i] <= addr <= REGION_LIMIT[i]`.
  - If `LIMIT < BASE`, the region never matches.
  - When several regions match, the lowest index wins.
- **States:** IDLE, WAIT, ACK.
- **IDLE.** On `cpu_valid`:
  - latch the address and decode it;
  - load the counter with the matched region's WS;
  - go to WAIT if WS>0, else go to ACK.
  - Without `cpu_valid`, stay in IDLE.
- **WAIT.**
  - `cpu_rdy`=0.
  - The counter decrements each cycle; when it is 1, go to ACK.
  - `cpu_valid` is ignored, because the CPU holds its address while stalled.
- **ACK.**
  - `ack`=1 for one cycle.
  - If `cpu_valid` is high, accept the new access exactly as IDLE would (back-to-back). Otherwise return to IDLE.
- **Select.** `select` and `region_idx` are valid from the cycle after acceptance through the ACK cycle inclusive. They are 0 in IDLE.
- **Unmapped address.**
  - `select`=0 and `region_idx`=0.
  - WS is forced to 0, so the access goes straight to ACK.
  - `decode_err`=1 during ACK.
- **Outputs.** `cpu_rdy` = (state != WAIT). All other outputs are registered.
- **Reset values:**
  - state IDLE;
  - `select`=0, `region_idx`=0;
  - `ack`=0, `decode_err`=0;
  - `cpu_rdy`=1;
  - counter 0;
  - `err_addr`=0.
- **Reset mid-access.** The access is abandoned immediately, with no `ack`.

## Timing
- Acceptance happens in cycle 0.
- `select` is valid in cycle 1.
- `ack` occurs in cycle 1+WS.
- `cpu_rdy` is low for exactly WS cycles, cycles 1..WS.
- Throughput is one access per 1+WS cycles when `cpu_valid` is held high.
- The decode path must close within one cycle at 16 regions.

## Configuration
- **With `ADDRESS_DECODER_WS_ERR_CAPTURE_EN` defined:**
  - On the first unmapped access, `err_addr` latches the address at acceptance. The capture is sticky and later errors do not overwrite it.
  - `err_clr` zeroes the capture and re-arms it.
  - If `err_clr` and a new error land in the same cycle, the new error is captured.
- **Without the macro:**
  - `err_addr` is tied to 0 and `err_clr` is ignored.
  - `decode_err` still pulses.

## Structure
- **Package `address_decoder_ws_pkg`** contains:
  - the state enum;
  - the default map constants, listed below.
- **Default map:**
  - region 0: 0x0000–0x3FFF, WS0;
  - region 1: 0x4000–0x4FFF, WS1;
  - region 2: 0x5000–0x6FFF, WS2;
  - region 3: 0x7000–0x7003, WS0;
  - region 4: 0x8000–0xFFFF, WS3.
- **Sub-module `region_match_m`.** One base/limit comparator, generate-instantiated once per region. A priority encoder in the top level produces the one-hot select and index.

## Test plan
- Reset, then `cpu_valid` with 0x1234: in cycle 1, `select`=5'b00001, `ack`=1, `cpu_rdy` stays 1.
- Access to 0x8000: `cpu_rdy` is 0 in cycles 1–3, `ack` fires in cycle 4, `select`=5'b10000 in cycles 1–4, `region_idx`=4.
- Back-to-back accesses 0x4000 then 0x7002 with `cpu_valid` held high: `ack` occurs in cycle 2 and cycle 3, and `select` changes 00010→01000 with no idle cycle between.
- Access to 0x7004 (unmapped): `select`=0, `decode_err`=1 with `ack` in cycle 1. With the macro, `err_addr`=0x7004; a later unmapped 0x7FFF leaves it unchanged; `err_clr` returns it to 0.
- Overlap: override region 3 to 0x0000–0xFFFF and access 0x2000: region 0 wins, `select`=00001.
- Assert `rst` during WAIT of a 0x9000 access: `cpu_rdy`=1 and `select`=0 immediately, no `ack`; a fresh access after release behaves normally.
